// File: rtl/regfile_pkg.sv
// Shared constants, read-result view and address-width helper for the rename register file.
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int ROB_W_DEF = 4;

   // Result of one read port at the default widths.
   typedef struct packed {
      logic                 ready;
      logic [XLEN_DEF-1:0]  val;
      logic [ROB_W_DEF-1:0] tag;
   } rd_result_t;

   function automatic int aw_of(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction
endpackage

// File: rtl/regfile_rename_if.sv
// Dispatch/ROB-facing bundle of the rename register file.
interface regfile_rename_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREG  = 32,
   parameter int ROB_W = ROB_W_DEF,
   parameter int NRD   = 2
);
   localparam int AW = aw_of(NREG);

   // No backpressure: issue_en/commit_en are valid-only strobes and are
   // accepted on any rising clock edge where rdy is high; rdy low freezes state.
   logic                 rdy;
   logic                 flush;
   logic [NRD*AW-1:0]    rs_a;
   logic [NRD-1:0]       rs_ready;
   logic [NRD*XLEN-1:0]  rs_val;
   logic [NRD*ROB_W-1:0] rs_tag;
   logic                 issue_en;
   logic [AW-1:0]        issue_rd;
   logic [ROB_W-1:0]     issue_tag;
   logic                 commit_en;
   logic [AW-1:0]        commit_rd;
   logic [ROB_W-1:0]     commit_tag;
   logic [XLEN-1:0]      commit_val;
   logic [AW:0]          busy_cnt;

   modport master (
      output rdy, flush, rs_a, issue_en, issue_rd, issue_tag,
             commit_en, commit_rd, commit_tag, commit_val,
      input  rs_ready, rs_val, rs_tag, busy_cnt
   );

   modport slave (
      input  rdy, flush, rs_a, issue_en, issue_rd, issue_tag,
             commit_en, commit_rd, commit_tag, commit_val,
      output rs_ready, rs_val, rs_tag, busy_cnt
   );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: stored-state lookup with same-cycle commit bypass.
module regfile_read_port #(
   parameter int XLEN  = 32,
   parameter int ROB_W = 4,
   parameter int AW    = 5
) (
   input  logic [AW-1:0]    addr,
   input  logic             busy,
   input  logic [XLEN-1:0]  stored_val,
   input  logic [ROB_W-1:0] stored_tag,
   input  logic             commit_live,
   input  logic [AW-1:0]    commit_rd,
   input  logic [ROB_W-1:0] commit_tag,
   input  logic [XLEN-1:0]  commit_val,
   output logic             ready,
   output logic [XLEN-1:0]  val,
   output logic [ROB_W-1:0] tag
);
   always_comb begin
      ready = 1'b1;
      val   = stored_val;
      tag   = stored_tag;
      if (addr == '0) begin
         val = '0;
         tag = '0;
      end else if (busy) begin
         // Only the commit that owns the current rename may forward its value.
         if (commit_live && commit_rd == addr && commit_tag == stored_tag)
            val = commit_val;
         else
            ready = 1'b0;
      end
   end
endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename (busy/tag) state and a live busy count.
module regfile_rename
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREG  = 32,
   parameter int ROB_W = ROB_W_DEF,
   parameter int NRD   = 2
) (
   input  logic          clk,
   input  logic          rst,
   regfile_rename_if.slave bus
);
   localparam int AW = aw_of(NREG);

   logic [XLEN-1:0]  val_q [NREG];
   logic [ROB_W-1:0] tag_q [NREG];
   logic [NREG-1:0]  busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;

   logic issue_wr, commit_wr, commit_clr, issue_set;

   logic [NRD-1:0]       rd_ready;
   logic [NRD*XLEN-1:0]  rd_val;
   logic [NRD*ROB_W-1:0] rd_tag;

   assign issue_wr   = bus.issue_en && bus.issue_rd != '0 && !bus.flush;
   assign commit_wr  = bus.commit_en && bus.commit_rd != '0;
   // A clear on the register being re-issued this cycle is absorbed by the issue.
   assign commit_clr = commit_wr && busy_q[bus.commit_rd]
                       && tag_q[bus.commit_rd] == bus.commit_tag
                       && !(issue_wr && bus.issue_rd == bus.commit_rd);
   assign issue_set  = issue_wr && !busy_q[bus.issue_rd];

   always_comb begin
      busy_d = busy_q;
      if (commit_clr) busy_d[bus.commit_rd] = 1'b0;
      if (bus.flush) busy_d = '0;
      else if (issue_wr) busy_d[bus.issue_rd] = 1'b1;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bus.flush) cnt_d = '0;
      else cnt_d = cnt_q + (AW+1)'(issue_set) - (AW+1)'(commit_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
         for (int r = 0; r < NREG; r++) begin
            val_q[r] <= '0;
            tag_q[r] <= '0;
         end
      end else if (bus.rdy) begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         if (commit_wr) val_q[bus.commit_rd] <= bus.commit_val;
         if (issue_wr)  tag_q[bus.issue_rd]  <= bus.issue_tag;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = bus.rs_a[i*AW +: AW];

      regfile_read_port #(.XLEN(XLEN), .ROB_W(ROB_W), .AW(AW)) u_port (
         .addr        (addr),
         .busy        (busy_q[addr]),
         .stored_val  (val_q[addr]),
         .stored_tag  (tag_q[addr]),
         .commit_live (bus.commit_en && bus.rdy),
         .commit_rd   (bus.commit_rd),
         .commit_tag  (bus.commit_tag),
         .commit_val  (bus.commit_val),
         .ready       (rd_ready[i]),
         .val         (rd_val[i*XLEN +: XLEN]),
         .tag         (rd_tag[i*ROB_W +: ROB_W])
      );
   end

   assign bus.rs_ready = rd_ready;
   assign bus.rs_val   = rd_val;
   assign bus.rs_tag   = rd_tag;
   assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: reference model plus expected-result queue.
module tb_regfile_rename;
   import regfile_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int ROB_W = 4;
   localparam int NRD   = 2;
   localparam int AW    = aw_of(NREG);
   localparam int W     = $bits(rd_result_t);

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_rename_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRD(NRD)) bus ();

   regfile_rename #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRD(NRD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // reference model
   logic [XLEN-1:0]  m_val  [NREG];
   logic [ROB_W-1:0] m_tag  [NREG];
   logic [NREG-1:0]  m_busy;

   logic [W-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int popcount(input logic [NREG-1:0] v);
      int n = 0;
      for (int r = 0; r < NREG; r++) n += int'(v[r]);
      return n;
   endfunction

   task automatic model_reset();
      m_busy = '0;
      for (int r = 0; r < NREG; r++) begin
         m_val[r] = '0;
         m_tag[r] = '0;
      end
   endtask

   task automatic model_clock();
      int cr, ir;
      cr = int'(bus.commit_rd);
      ir = int'(bus.issue_rd);
      if (!bus.rdy) return;
      if (bus.commit_en && cr != 0) begin
         m_val[cr] = bus.commit_val;
         if (m_tag[cr] == bus.commit_tag) m_busy[cr] = 1'b0;
      end
      if (bus.flush) m_busy = '0;
      else if (bus.issue_en && ir != 0) begin
         m_busy[ir] = 1'b1;
         m_tag[ir]  = bus.issue_tag;
      end
   endtask

   // driver tasks
   task automatic idle();
      bus.flush     = 1'b0;
      bus.issue_en  = 1'b0;
      bus.issue_rd  = '0;
      bus.issue_tag = '0;
      bus.commit_en = 1'b0;
      bus.commit_rd = '0;
      bus.commit_tag = '0;
      bus.commit_val = '0;
   endtask

   task automatic drive_issue(input int rd, input int tag);
      bus.issue_en  = 1'b1;
      bus.issue_rd  = AW'(rd);
      bus.issue_tag = ROB_W'(tag);
   endtask

   task automatic drive_commit(input int rd, input int tag, input logic [XLEN-1:0] v);
      bus.commit_en  = 1'b1;
      bus.commit_rd  = AW'(rd);
      bus.commit_tag = ROB_W'(tag);
      bus.commit_val = v;
   endtask

   task automatic push_exp(input int a);
      rd_result_t r;
      r.ready = 1'b1;
      r.val   = m_val[a];
      r.tag   = m_tag[a];
      if (a == 0) begin
         r.val = '0;
         r.tag = '0;
      end else if (m_busy[a]) begin
         if (bus.commit_en && bus.rdy && int'(bus.commit_rd) == a && bus.commit_tag == m_tag[a])
            r.val = bus.commit_val;
         else
            r.ready = 1'b0;
      end
      exp_q.push_back(r);
   endtask

   // Drive both read addresses, queue expectations, then compare the combinational outputs.
   task automatic read2(input int a0, input int a1, input string tag);
      bus.rs_a = {AW'(a1), AW'(a0)};
      push_exp(a0);
      push_exp(a1);
      #1;
      for (int p = 0; p < NRD; p++) begin
         logic [W-1:0] e, o, m;
         e = exp_q.pop_front();
         o = {bus.rs_ready[p], bus.rs_val[p*XLEN +: XLEN], bus.rs_tag[p*ROB_W +: ROB_W]};
         m = e[W-1] ? {1'b1, {XLEN{1'b1}}, {ROB_W{1'b0}}} : {W{1'b1}};
         check($sformatf("%s_p%0d", tag, p), 64'(o & m), 64'(e & m));
      end
   endtask

   task automatic check_cnt(input string tag);
      check(tag, 64'(bus.busy_cnt), 64'(popcount(m_busy)));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      idle();
   endtask

   initial begin
      bus.rdy  = 1'b1;
      bus.rs_a = '0;
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state
      read2(5, 0, "reset_rd");
      check_cnt("reset_cnt");

      // simple rename, bypassed commit, retire
      drive_issue(3, 7);
      cycle();
      read2(3, 0, "r3_busy");
      check(("r3_tag"), 64'(bus.rs_tag[0 +: ROB_W]), 64'(7));
      check_cnt("r3_cnt1");
      drive_commit(3, 7, 32'hDEAD);
      read2(3, 3, "r3_bypass");
      cycle();
      read2(3, 0, "r3_done");
      check_cnt("r3_cnt0");

      // stale commit does not free a younger rename
      drive_issue(4, 2);
      cycle();
      drive_issue(4, 9);
      cycle();
      drive_commit(4, 2, 32'h11);
      cycle();
      read2(4, 3, "r4_young");
      check_cnt("r4_cnt");
      drive_commit(4, 9, 32'h22);
      cycle();
      read2(4, 0, "r4_done");

      // same-cycle issue and mismatched commit on one register
      drive_issue(6, 5);
      drive_commit(6, 1, 32'h33);
      cycle();
      read2(6, 4, "r6_both");
      check_cnt("r6_cnt");
      drive_commit(6, 5, 32'h34);
      cycle();

      // flush with concurrent commit and issue
      drive_issue(1, 1); cycle();
      drive_issue(2, 2); cycle();
      drive_issue(3, 3); cycle();
      check_cnt("pre_flush_cnt");
      bus.flush = 1'b1;
      drive_commit(2, 0, 32'h44);
      drive_issue(7, 6);
      cycle();
      read2(2, 7, "flush_a");
      read2(1, 3, "flush_b");
      check_cnt("flush_cnt");

      // rdy low freezes state
      bus.rdy = 1'b0;
      drive_issue(8, 3);
      drive_commit(5, 0, 32'h55);
      cycle();
      read2(8, 5, "hold");
      check_cnt("hold_cnt");
      bus.rdy = 1'b1;

      // asynchronous reset between edges
      drive_issue(9, 4); cycle();
      drive_issue(10, 8); cycle();
      check_cnt("pre_rst_cnt");
      #1 rst = 1'b1;
      #1 model_reset();
      read2(9, 10, "async_rst_a");
      read2(2, 4, "async_rst_b");
      check_cnt("async_rst_cnt");
      #1 rst = 1'b0;
      @(negedge clk);

      // randomized traffic on a small register window
      for (int n = 0; n < 300; n++) begin
         int cr;
         if ($urandom_range(0, 1) == 1) drive_issue($urandom_range(0, 7), $urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            cr = $urandom_range(0, 7);
            drive_commit(cr, ($urandom_range(0, 1) == 1) ? int'(m_tag[cr]) : $urandom_range(0, 15),
                         XLEN'($urandom()));
         end
         bus.flush = ($urandom_range(0, 19) == 0);
         read2($urandom_range(0, 7), $urandom_range(0, 7), "rand_rd");
         cycle();
         check_cnt("rand_cnt");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
